// File: rtl/seq_window_shifter.sv
// seq_window_shifter: streams packed symbol words into a double-width buffer and
// presents an MSB-aligned comparison window that the matcher advances by
// 0..SHIFT_MAX symbols per cycle while the buffer refills concurrently.
//
// Buffer invariant: the valid bits sit in the top `fill` bits of buf_q and every
// bit below them is zero, so the window is always buf_q[BUF_W-1 -: WIN_W] and
// loads can simply be ORed in just below the surviving data.
//
// Optional feature (macro SEQ_WIN_POS_EN): adds output sym_pos, the number of
// symbols shifted out since the last IDLE -> STREAM transition (wraps at 2^32).
module seq_window_shifter #(
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned SYM_W     = 2,
    parameter int unsigned WIN_W     = 512,
    parameter int unsigned SHIFT_MAX = 16,
    localparam int unsigned BUF_W    = WIN_W + DATA_W,
    localparam int unsigned SN_W     = $clog2(SHIFT_MAX + 1),
    localparam int unsigned FILL_W   = $clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    // Input word stream
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    // Window advance requests from the matcher
    input  logic              shift_valid,
    input  logic [SN_W-1:0]   shift_num,
    output logic              shift_ready,
    // Comparison window
    output logic [WIN_W-1:0]  win_data,
    output logic              win_valid,
    output logic [FILL_W-1:0] win_fill,
`ifdef SEQ_WIN_POS_EN
    output logic [31:0]       sym_pos,
`endif
    output logic              done
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStream = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    logic              load_acc;
    logic              shift_acc;
    logic [31:0]       shift_bits;
    logic [FILL_W-1:0] shift_amt;
    logic [FILL_W-1:0] fill_kept;
    logic [BUF_W-1:0]  buf_shifted;
    logic [BUF_W-1:0]  load_vec;

    // Handshake readiness and window qualification from registered state.
    // shift_ready is deliberately combinational from shift_num so the matcher
    // learns in the same cycle whether the requested advance fits in the buffer.
    always_comb begin
        in_ready   = (state_q != StDrain) && (fill_q <= FILL_W'(WIN_W));
        win_valid  = 1'b0;
        unique case (state_q)
            StStream: win_valid = (fill_q >= FILL_W'(WIN_W));
            StDrain:  win_valid = (fill_q != '0);
            default:  win_valid = 1'b0;
        endcase
        // 32-bit product so an out-of-range shift_num can never wrap to a small value
        shift_bits  = 32'(shift_num) * SYM_W;
        shift_ready = win_valid && (shift_bits <= 32'(fill_q));
        load_acc    = in_valid && in_ready;
        shift_acc   = shift_valid && shift_ready;
    end

    // Buffer datapath: shift out the consumed head, then drop the new word in
    // directly below the bits that survive the shift.
    always_comb begin
        // Accepted shifts never exceed fill, so the truncation is lossless
        shift_amt   = shift_acc ? shift_bits[FILL_W-1:0] : '0;
        fill_kept   = fill_q - shift_amt;
        buf_shifted = buf_q << shift_amt;
        // Loads only happen with fill <= WIN_W, so the word always fits below fill_kept
        load_vec    = {in_data, {WIN_W{1'b0}}} >> fill_kept;
        buf_d       = load_acc ? (buf_shifted | load_vec) : buf_shifted;
        fill_d      = load_acc ? (fill_kept + FILL_W'(DATA_W)) : fill_kept;
    end

    // Stream-level state: idle until the first word, drain after the last one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_acc) begin
                    state_d = in_last ? StDrain : StStream;
                end
            end
            StStream: begin
                if (load_acc && in_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fill_d == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // done marks the cycle in which the final drain shift empties the buffer;
    // gating with rst keeps it quiet while the block is being reset.
    always_comb begin
        done = !rst && (state_q == StDrain) && (fill_d == '0);
    end

    // State, buffer and fill registers; reset discards any in-flight handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    // Window outputs are straight taps of the registered buffer.
    always_comb begin
        win_data = buf_q[BUF_W-1 -: WIN_W];
        win_fill = fill_q;
    end

`ifdef SEQ_WIN_POS_EN
    logic [31:0] pos_q, pos_d;

    // Symbol position: restarts with each new stream, advances by accepted shifts.
    always_comb begin
        pos_d = pos_q;
        if ((state_q == StIdle) && (state_d == StStream)) begin
            pos_d = '0;
        end else if (shift_acc) begin
            pos_d = pos_q + 32'(shift_num);
        end
    end

    // Position register, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    // Position output tap.
    always_comb begin
        sym_pos = pos_q;
    end
`endif

endmodule

// File: tb/tb_seq_window_shifter.sv
// Testbench for seq_window_shifter (default parameters). The stimulus process
// pushes hand-computed expectations tagged with the cycle they apply to; a
// separate monitor pops and compares them at the falling edge of that cycle.
// Define SEQ_WIN_POS_EN to also check the sym_pos output.
module tb_seq_window_shifter;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned SYM_W  = 2;
    localparam int unsigned WIN_W  = 512;
    localparam int unsigned SHIFT_MAX = 16;
    localparam int unsigned SN_W   = $clog2(SHIFT_MAX + 1);
    localparam int unsigned FILL_W = $clog2(WIN_W + DATA_W + 1);

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              shift_valid;
    logic [SN_W-1:0]   shift_num;
    logic              shift_ready;
    logic [WIN_W-1:0]  win_data;
    logic              win_valid;
    logic [FILL_W-1:0] win_fill;
    logic              done;
`ifdef SEQ_WIN_POS_EN
    logic [31:0]       sym_pos;
`endif

    seq_window_shifter #(
        .DATA_W    (DATA_W),
        .SYM_W     (SYM_W),
        .WIN_W     (WIN_W),
        .SHIFT_MAX (SHIFT_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .shift_valid (shift_valid),
        .shift_num   (shift_num),
        .shift_ready (shift_ready),
        .win_data    (win_data),
        .win_valid   (win_valid),
        .win_fill    (win_fill),
`ifdef SEQ_WIN_POS_EN
        .sym_pos     (sym_pos),
`endif
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         cyc;
        bit         is_pos;
        bit         chk_data;
        logic [511:0] data;
        int         fill;
        bit         wv;
        bit         ir;
        bit         sr;
        bit         dn;
        logic [31:0] pos;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every expectation due this cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                chk({e.name, "_late"}, 512'(cyc), 512'(e.cyc));
            end else if (e.is_pos) begin
`ifdef SEQ_WIN_POS_EN
                chk({e.name, "_sym_pos"}, 512'(sym_pos), 512'(e.pos));
`endif
            end else begin
                if (e.chk_data) chk({e.name, "_win_data"}, win_data, e.data);
                chk({e.name, "_win_fill"}, 512'(win_fill), 512'(e.fill));
                chk({e.name, "_win_valid"}, 512'(win_valid), 512'(e.wv));
                chk({e.name, "_in_ready"}, 512'(in_ready), 512'(e.ir));
                chk({e.name, "_shift_ready"}, 512'(shift_ready), 512'(e.sr));
                chk({e.name, "_done"}, 512'(done), 512'(e.dn));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input bit cd, input logic [511:0] d, input int f,
                             input bit wv, input bit ir, input bit sr, input bit dn);
        exp_t e;
        e.name = nm; e.cyc = cyc; e.is_pos = 1'b0; e.chk_data = cd; e.data = d;
        e.fill = f; e.wv = wv; e.ir = ir; e.sr = sr; e.dn = dn; e.pos = '0;
        sb_q.push_back(e);
    endtask

    task automatic expect_pos(input string nm, input logic [31:0] p);
`ifdef SEQ_WIN_POS_EN
        exp_t e;
        e.name = nm; e.cyc = cyc; e.is_pos = 1'b1; e.chk_data = 1'b0; e.data = '0;
        e.fill = 0; e.wv = 0; e.ir = 0; e.sr = 0; e.dn = 0; e.pos = p;
        sb_q.push_back(e);
`else
        if (nm.len() == 0) $display("empty expectation name %0d", p);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        shift_valid = 1'b0; shift_num = '0;
        tick();
        rst = 1'b0;
    endtask

    logic [511:0] wa, wb, wc, wd;
    int f;
    bit ld;
    bit acc;
    bit seen;

    initial begin
        wa = {8{64'h0123_4567_89AB_CDEF}};
        wb = {8{64'hFEDC_BA98_7654_3210}};
        wc = {16{32'hDEAD_BEEF}};
        wd = {16{32'hC0FF_EE11}};

        // Reset state
        do_reset();
        rst = 1'b1;
        tick();
        expect_st("reset", 1, '0, 0, 0, 1, 0, 0);
        expect_pos("reset", 0);
        rst = 1'b0;

        // Fill from empty: A then B, then a one-symbol shift
        in_valid = 1'b1; in_data = wa;
        tick();
        in_data = wb;
        expect_st("after_a", 1, wa, 512, 1, 1, 1, 0);
        tick();
        in_valid = 1'b0; shift_valid = 1'b1; shift_num = 1;
        expect_st("after_b", 1, wa, 1024, 1, 0, 1, 0);
        tick();
        shift_valid = 1'b0; shift_num = 0;
        expect_st("shift1", 1, {wa[509:0], wb[511:510]}, 1022, 1, 0, 1, 0);

        // Shift by 3 and load C in the same cycle at fill=512
        do_reset();
        in_valid = 1'b1; in_data = wa;
        tick();
        in_data = wc; shift_valid = 1'b1; shift_num = 3;
        expect_st("a_again", 1, wa, 512, 1, 1, 1, 0);
        tick();
        in_valid = 1'b0; shift_valid = 1'b0; shift_num = 0;
        expect_st("shift3_load_c", 1, {wa[505:0], wc[511:506]}, 1018, 1, 0, 1, 0);

        // Reset mid-stream at fill=1024 with handshakes in flight
        do_reset();
        in_valid = 1'b1; in_data = wa;
        tick();
        in_data = wb;
        tick();
        rst = 1'b1; in_data = wc; shift_valid = 1'b1; shift_num = 16;
        expect_st("pre_rst_full", 1, wa, 1024, 1, 0, 1, 0);
        tick();
        rst = 1'b0; in_valid = 1'b0; shift_valid = 1'b0; shift_num = 0;
        expect_st("rst_mid", 1, '0, 0, 0, 1, 0, 0);
        expect_pos("rst_mid", 0);

        // Single last word, drain down to fill=4, over-shift, then finish
        in_valid = 1'b1; in_data = wd; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; shift_valid = 1'b1; shift_num = 16;
        expect_st("drain_entry", 1, wd, 512, 1, 0, 1, 0);
        repeat (15) tick();
        shift_num = 14;
        expect_st("drain_32", 0, '0, 32, 1, 0, 1, 0);
        tick();
        shift_num = 3;
        expect_st("overshift", 1, {wd[3:0], {508{1'b0}}}, 4, 1, 0, 0, 0);
        tick();
        shift_num = 2;
        expect_st("overshift_hold", 1, {wd[3:0], {508{1'b0}}}, 4, 1, 0, 1, 1);
        tick();
        shift_valid = 1'b0; shift_num = 0;
        expect_st("drain_done", 1, '0, 0, 0, 1, 0, 0);

        // Steady streaming: 40 shifts of 16 symbols with continuous refill
        in_valid = 1'b1; in_data = wa; in_last = 1'b0;
        tick();
        in_data = wb; shift_valid = 1'b1; shift_num = 16;
        f = 512;
        for (int i = 0; i < 40; i++) begin
            ld = (f <= 512);
            expect_st($sformatf("stream%0d", i), 0, '0, f, 1, ld, 1, 0);
            f = f - 32 + (ld ? 512 : 0);
            tick();
        end
        in_valid = 1'b0; shift_valid = 1'b0; shift_num = 0;
        expect_st("stream_end", 0, '0, f, 1, (f <= 512), 1, 0);
        expect_pos("pos_640", 640);

        // Send a last word and drain until done, bounded
        in_valid = 1'b1; in_data = wc; in_last = 1'b1;
        shift_valid = 1'b1; shift_num = 16;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            acc  = in_valid && in_ready;
            seen = done;
            tick();
            if (acc) begin
                in_valid = 1'b0; in_last = 1'b0;
            end
        end
        chk("drain_done_seen", 512'(seen), 512'(1));
        in_valid = 1'b0; in_last = 1'b0; shift_valid = 1'b0; shift_num = 0;
        expect_st("idle_again", 0, '0, 0, 0, 1, 0, 0);

        // New stream start clears the position
        in_valid = 1'b1; in_data = wa;
        tick();
        in_valid = 1'b0;
        expect_st("restream", 1, wa, 512, 1, 1, 1, 0);
        expect_pos("pos_cleared", 0);

        tick();
        tick();
        chk("scoreboard_empty", 512'(sb_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_window_shifter.md
# seq_window_shifter

Parametrised symbol-window shifter for the sequence-compare datapath. It streams packed nucleotide words (2 bits per symbol by default) into a double-width buffer and presents a fixed-width, MSB-aligned comparison window. The downstream matcher advances the window by 0..SHIFT_MAX symbols per cycle, and the buffer refills concurrently. Successor to the fixed 512-bit / 1-symbol shifter: width, symbol size and shift amount are generic, and it adds valid/ready handshakes, fill tracking and end-of-stream drain.

## Interface
- DATA_W, 512: input word width in bits; must be a multiple of SYM_W.
- SYM_W, 2: bits per symbol.
- WIN_W, 512: output window width in bits; must be a multiple of SYM_W. Internal buffer BUF_W = WIN_W + DATA_W.
- SHIFT_MAX, 16: maximum symbols per shift; SHIFT_MAX*SYM_W <= WIN_W.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  DATA_W  packed symbols; first symbol in MSBs.
- in_last  in  1  marks final word of a sequence.
- shift_valid  in  1  shift request.
- shift_num  in  clog2(SHIFT_MAX+1)  symbols to discard from window head.
- shift_ready  out  1  shift accepted when shift_valid & shift_ready.
- win_data  out  WIN_W  buf[BUF_W-1 -: WIN_W].
- win_valid  out  1  window content usable.
- win_fill  out  clog2(BUF_W+1)  valid bits in buffer (fill).
- done  out  1  one-cycle pulse when drain completes.

## Operation
- Buffer buf[BUF_W-1:0]; valid bits occupy the top fill bits and all bits below are zero (invariant).
- States: IDLE (fill=0), STREAM, DRAIN.
- IDLE -> STREAM on an accepted word; STREAM -> DRAIN on an accepted word with in_last=1 (also from IDLE); DRAIN -> IDLE with done=1 in the cycle fill becomes 0.
- in_ready = (state != DRAIN) && (fill <= WIN_W). It does not depend on the same-cycle shift.
- win_valid: STREAM: fill >= WIN_W; DRAIN: fill > 0; IDLE: 0.
- shift_ready = win_valid && (shift_num*SYM_W <= fill). This path is combinational from shift_num.
- Let s = shift_num*SYM_W if a shift is accepted, else 0. Let L = 1 if a load is accepted.
- Next state of the buffer: buf_next = (buf << s), then, if L, in_data is ORed at buf_next[BUF_W-1-(fill-s) -: DATA_W].
- fill_next = fill - s + L*DATA_W.
- shift_num=0 with shift_valid is accepted as a no-op.
- Shift and load in the same cycle are both applied as above; this is the normal steady-state case.
- In DRAIN, bits of win_data below win_fill are zero-padded.

## Timing
- Reset: buf=0, fill=0, state IDLE, in_ready=1, shift_ready=0, win_valid=0, win_data=0, win_fill=0, done=0.
- Accepted word or shift is visible on win_data/win_fill the cycle after acceptance (latency 1).
- Handshakes follow valid/ready rules: the source holds in_data/in_last until accepted. The core never waits on valid to assert ready.
- Reset asserted mid-stream discards all buffered data the next cycle; in-flight handshakes that cycle are ignored.
- done is never asserted together with reset.

## Configuration
- SEQ_WIN_POS_EN defined: adds output sym_pos [31:0], the count of symbols shifted out since the last IDLE -> STREAM transition.
  - Increments by shift_num on each accepted shift and wraps at 2^32.
  - Cleared by reset and on the transition into STREAM.
  - Used by the hit reporter for query offsets.
- Undefined: the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Fill from reset with defaults: word A, then word B -> after A: fill=512, win_valid=1, win_data=A, in_ready=1. After B: fill=1024, in_ready=0.
- From fill=1024, shift_num=1 -> fill=1022, win_data={A[509:0],B[511:510]}, in_ready=0.
- Simultaneous shift_num=3 and load C at fill=512 -> fill=1018, C at buf[517:6], win_data={A[505:0],C[511:506]}.
- Over-shift: fill=4 in DRAIN, shift_num=3 -> shift_ready=0, state unchanged. shift_num=2 -> fill=0, done pulses one cycle, state IDLE.
- Reset mid-stream at fill=1024 -> next cycle fill=0, win_valid=0, in_ready=1, sym_pos=0 (with SEQ_WIN_POS_EN).
- SEQ_WIN_POS_EN: 40 shifts of 16 symbols during streaming -> sym_pos=640. A new stream start clears it to 0.
